// File: rtl/move_queue_pkg.sv
// Shared move encoding for the cube robot: move-code width, face/direction
// constants, FSM state types and the terminator test.
package rbot_moves_pkg;

    localparam int MOVE_W          = 4;
    localparam int NUM_VALID_MOVES = 12;

    typedef logic [MOVE_W-1:0] move_t;

    // Move code = face*2 + dir
    localparam logic [2:0] FACE_U  = 3'd0;
    localparam logic [2:0] FACE_D  = 3'd1;
    localparam logic [2:0] FACE_F  = 3'd2;
    localparam logic [2:0] FACE_B  = 3'd3;
    localparam logic [2:0] FACE_L  = 3'd4;
    localparam logic [2:0] FACE_R  = 3'd5;
    localparam logic       DIR_CW  = 1'b0;
    localparam logic       DIR_CCW = 1'b1;

    localparam move_t MOVE_TERM = 4'd15;

    typedef enum logic [0:0] {
        L_IDLE   = 1'b0,
        L_UNPACK = 1'b1
    } load_state_t;

    typedef enum logic [2:0] {
        I_IDLE      = 3'd0,
        I_START     = 3'd1,
        I_WAIT_BUSY = 3'd2,
        I_WAIT_DONE = 3'd3,
        I_SETTLE    = 3'd4
    } issue_state_t;

    // Codes 12..15 end a packed burst
    function automatic logic is_terminator(input move_t m);
        return (m >= move_t'(NUM_VALID_MOVES));
    endfunction

    function automatic move_t make_move(input logic [2:0] face, input logic dir);
        return {face, dir};
    endfunction

endpackage

// File: rtl/move_queue_if.sv
// Handshake between the move queue (master) and the stepper executor (slave).
interface move_queue_if;
    import rbot_moves_pkg::*;

    move_t next_move;
    logic  move_start;
    logic  move_done;
    logic  seq_done;

    modport master (
        output next_move,
        output move_start,
        output seq_done,
        input  move_done
    );

    modport slave (
        input  next_move,
        input  move_start,
        input  seq_done,
        output move_done
    );
endinterface

// File: rtl/move_queue_fifo.sv
// Circular move FIFO with wrapping pointers; push and pop may coincide.
module move_fifo
    import rbot_moves_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  move_t                      din,
    output move_t                      dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    move_t            mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Storage write; contents need no reset since occupancy gates reads
    always_ff @(posedge clock) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == '0);
    assign count = count_r;

endmodule

// File: rtl/move_queue.sv
// Move queue: unpacks a packed burst of moves into a FIFO and feeds them one
// at a time to the stepper executor with a settle gap after each move.
module move_queue
    import rbot_moves_pkg::*;
#(
    parameter int DEPTH         = 64,
    parameter int MAX_LOAD      = 50,
    parameter int SETTLE_CYCLES = 25000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       load,
    input  logic [MOVE_W*MAX_LOAD-1:0] seq,
    output logic                       loading,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] count,
    move_queue_if.master               exe
);
    localparam int IDX_W = $clog2(MAX_LOAD);
    localparam int SET_W = $clog2(SETTLE_CYCLES+1);

    load_state_t                l_state_r;
    logic [MOVE_W*MAX_LOAD-1:0] shift_r;
    logic [IDX_W-1:0]           idx_r;
    logic                       loading_r;
    logic                       overflow_r;

    issue_state_t               i_state_r;
    logic [SET_W-1:0]           settle_r;
    move_t                      next_move_r;
    logic                       move_start_r;
    logic                       seq_done_r;
    logic                       issued_r;

    move_t                      cur_s;
    move_t                      head_s;
    logic                       push_s;
    logic                       pop_s;
    logic                       full_s;
    logic                       empty_s;

    move_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (cur_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count)
    );

    // Current move under the unpacker, and FIFO push/pop strobes
    always_comb begin
        cur_s  = shift_r[MOVE_W-1:0];
        push_s = 1'b0;
        pop_s  = 1'b0;
        if ((l_state_r == L_UNPACK) && !is_terminator(cur_s) && !full_s) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if ((i_state_r == I_IDLE) && !empty_s && exe.move_done) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Loader FSM: capture a burst, then scan one move per cycle until terminator or last slot
    always_ff @(posedge clock) begin
        if (reset) begin
            l_state_r  <= L_IDLE;
            shift_r    <= '0;
            idx_r      <= '0;
            loading_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (l_state_r)
                L_IDLE: begin
                    if (load) begin
                        shift_r   <= seq;
                        idx_r     <= '0;
                        loading_r <= 1'b1;
                        l_state_r <= L_UNPACK;
                    end
                end
                L_UNPACK: begin
                    if (!is_terminator(cur_s) && full_s) begin
                        overflow_r <= 1'b1;
                    end
                    shift_r <= shift_r >> MOVE_W;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (is_terminator(cur_s) || (idx_r == IDX_W'(MAX_LOAD-1))) begin
                        loading_r <= 1'b0;
                        l_state_r <= L_IDLE;
                    end
                end
                default: begin
                    loading_r <= 1'b0;
                    l_state_r <= L_IDLE;
                end
            endcase
        end
    end

    // Issue FSM: pop, pulse start, follow executor busy/done, then settle before the next move
    always_ff @(posedge clock) begin
        if (reset) begin
            i_state_r    <= I_IDLE;
            settle_r     <= '0;
            next_move_r  <= '0;
            move_start_r <= 1'b0;
            seq_done_r   <= 1'b0;
            issued_r     <= 1'b0;
        end else begin
            move_start_r <= 1'b0;
            seq_done_r   <= 1'b0;
            case (i_state_r)
                I_IDLE: begin
                    if (pop_s) begin
                        next_move_r  <= head_s;
                        move_start_r <= 1'b1;
                        issued_r     <= 1'b1;
                        i_state_r    <= I_START;
                    end
                end
                I_START: begin
                    i_state_r <= I_WAIT_BUSY;
                end
                I_WAIT_BUSY: begin
                    if (!exe.move_done) begin
                        i_state_r <= I_WAIT_DONE;
                    end
                end
                I_WAIT_DONE: begin
                    if (exe.move_done) begin
                        settle_r  <= SET_W'(SETTLE_CYCLES-1);
                        i_state_r <= I_SETTLE;
                    end
                end
                I_SETTLE: begin
                    if (settle_r == '0) begin
                        i_state_r <= I_IDLE;
                        // Only report a drain when something was actually issued
                        if (empty_s && !loading_r && issued_r) begin
                            seq_done_r <= 1'b1;
                            issued_r   <= 1'b0;
                        end
                    end else begin
                        settle_r <= settle_r - SET_W'(1);
                    end
                end
                default: begin
                    i_state_r <= I_IDLE;
                end
            endcase
        end
    end

    assign loading        = loading_r;
    assign overflow       = overflow_r;
    assign exe.next_move  = next_move_r;
    assign exe.move_start = move_start_r;
    assign exe.seq_done   = seq_done_r;

endmodule

// File: tb/tb_move_queue.sv
// Scoreboard bench for move_queue: stimulus pushes expected moves, a monitor
// pops and compares on every move_start, an executor model drives move_done.
module tb_move_queue;
    localparam int DEPTH    = 8;
    localparam int MAX_LOAD = 12;
    localparam int SETTLE   = 4;
    localparam int BUSY     = 10;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic [47:0] seq;
    logic        loading;
    logic        overflow;
    logic [3:0]  count;
    logic        exec_done;
    logic        hold_low;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;
    int sd_cnt    = 0;
    int exp_q[$];

    move_queue_if ifc();
    assign ifc.move_done = exec_done & ~hold_low;

    move_queue #(.DEPTH(DEPTH), .MAX_LOAD(MAX_LOAD), .SETTLE_CYCLES(SETTLE)) dut (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .seq      (seq),
        .loading  (loading),
        .overflow (overflow),
        .count    (count),
        .exe      (ifc)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Executor model: goes busy 2 cycles after a start, finishes BUSY cycles later
    initial begin
        exec_done = 1'b1;
        forever begin
            @(negedge clock);
            if (ifc.move_start) begin
                repeat (2) @(negedge clock);
                exec_done = 1'b0;
                repeat (BUSY) @(negedge clock);
                exec_done = 1'b1;
            end
        end
    end

    // Monitor: every start pulse must carry the next expected move
    initial begin
        forever begin
            @(negedge clock);
            if (ifc.move_start) begin
                start_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start: got move %0d expected no start", ifc.next_move);
                end else begin
                    check("next_move", int'(ifc.next_move), exp_q.pop_front());
                end
            end
            if (ifc.seq_done) sd_cnt++;
        end
    end

    task automatic pulse_load(input logic [47:0] s);
        seq  = s;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic wait_seq_done(input string name, input int budget);
        int base = sd_cnt;
        int k = 0;
        while (sd_cnt == base && k < budget) begin
            @(negedge clock);
            k++;
        end
        check({name, "_seq_done"}, sd_cnt - base, 1);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int base;
        int seen;
        reset = 1'b1; load = 1'b0; seq = 48'h0; hold_low = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_count", int'(count), 0);
        check("rst_loading", int'(loading), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_next_move", int'(ifc.next_move), 0);
        check("rst_move_start", int'(ifc.move_start), 0);
        check("rst_seq_done", int'(ifc.seq_done), 0);
        reset = 1'b0;
        @(negedge clock);

        // T1: moves 0,7,3 then terminator
        base = start_cnt;
        exp_q.push_back(0); exp_q.push_back(7); exp_q.push_back(3);
        pulse_load(48'hFFFF_FFFF_F370);
        wait_seq_done("t1", 400);
        check("t1_starts", start_cnt - base, 3);
        check("t1_overflow", int'(overflow), 0);
        check("t1_count", int'(count), 0);

        // T6: executor busy at fill, start follows release within 2 cycles
        base = start_cnt;
        hold_low = 1'b1;
        exp_q.push_back(4);
        pulse_load(48'hFFFF_FFFF_FFF4);
        repeat (10) @(negedge clock);
        check("t6_count_held", int'(count), 1);
        check("t6_no_start", start_cnt - base, 0);
        hold_low = 1'b0;
        seen = 0;
        for (int k = 0; k < 2 && seen == 0; k++) begin
            @(negedge clock);
            if (ifc.move_start) seen = 1;
        end
        check("t6_start_latency", seen, 1);
        wait_seq_done("t6", 200);

        // T3: load during loading is ignored
        base = start_cnt;
        hold_low = 1'b1;
        exp_q.push_back(2); exp_q.push_back(3);
        pulse_load(48'hFFFF_FFFF_FF32);
        check("t3_loading", int'(loading), 1);
        pulse_load(48'hFFFF_FFFF_FFF5);
        repeat (6) @(negedge clock);
        check("t3_count", int'(count), 2);
        hold_low = 1'b0;
        wait_seq_done("t3", 300);
        check("t3_starts", start_cnt - base, 2);

        // T4: second burst pushes in the same cycle as a pop, pointers wrap
        base = start_cnt;
        hold_low = 1'b1;
        exp_q.push_back(6); exp_q.push_back(7); exp_q.push_back(8);
        exp_q.push_back(9); exp_q.push_back(10); exp_q.push_back(11);
        pulse_load(48'hFFFF_FFFF_F876);
        repeat (6) @(negedge clock);
        check("t4_count_a", int'(count), 3);
        pulse_load(48'hFFFF_FFFF_FBA9);
        hold_low = 1'b0;
        check("t4_count_pre", int'(count), 3);
        @(negedge clock);
        check("t4_push_pop_same_cycle", int'(count), 3);
        wait_seq_done("t4", 600);
        check("t4_starts", start_cnt - base, 6);
        check("t4_overflow", int'(overflow), 0);

        // T2: 12 valid moves into 8 entries, executor held busy
        base = start_cnt;
        hold_low = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(i);
        pulse_load(48'hBA98_7654_3210);
        repeat (14) @(negedge clock);
        check("t2_count_full", int'(count), 8);
        check("t2_overflow", int'(overflow), 1);
        check("t2_loading_end", int'(loading), 0);
        hold_low = 1'b0;
        wait_seq_done("t2", 800);
        check("t2_starts", start_cnt - base, 8);
        check("t2_overflow_sticky", int'(overflow), 1);

        // T5: reset while waiting for the executor to finish
        hold_low = 1'b1;
        pulse_load(48'hFFFF_FFB9_7531);
        repeat (10) @(negedge clock);
        check("t5_count", int'(count), 6);
        exp_q.push_back(1);
        base = start_cnt;
        hold_low = 1'b0;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t5_rst_count", int'(count), 0);
        check("t5_rst_overflow", int'(overflow), 0);
        check("t5_rst_loading", int'(loading), 0);
        check("t5_rst_next_move", int'(ifc.next_move), 0);
        check("t5_rst_move_start", int'(ifc.move_start), 0);
        reset = 1'b0;
        seen = sd_cnt;
        repeat (40) @(negedge clock);
        check("t5_starts", start_cnt - base, 1);
        check("t5_no_seq_done", sd_cnt - seen, 0);
        check("t5_count_after", int'(count), 0);
        check("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/move_queue.md
Name: move_queue

Overview:
- Buffers cube-turn moves between the solver/sequence source and the stepper executor `move_to_step`.
- Accepts a packed burst of up to MAX_LOAD 4-bit moves and unpacks it into an internal FIFO.
- Issues the moves one at a time using the executor's `next_move` / `move_start` / `move_done` handshake, with a settle gap after each move.
- Reports when the whole queue has drained.

Parameters:
- DEPTH, 64: FIFO entries (power of two).
- MAX_LOAD, 50: moves per packed burst; `seq` width = 4*MAX_LOAD.
- SETTLE_CYCLES, 25000: idle cycles after each completed move (1 ms at 25 MHz).

Ports:
- clock  in  1  system clock (25 MHz).
- reset  in  1  synchronous, active-high.
- load  in  1  one-cycle pulse; capture `seq` and start unpacking.
- seq  in  4*MAX_LOAD  packed moves, move 0 in bits [3:0].
- loading  out  1  high while a burst is being unpacked.
- overflow  out  1  sticky; a move was dropped because the FIFO was full.
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.
- next_move  out  4  move code presented to the executor.
- move_start  out  1  one-cycle start pulse.
- move_done  in  1  executor status level: high = idle/finished, low = moving.
- seq_done  out  1  one-cycle pulse when all queued moves have completed.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - Reset values: `loading`=0, `overflow`=0, `count`=0, `next_move`=0, `move_start`=0, `seq_done`=0.
  - Both FSMs return to IDLE, FIFO pointers clear, and any in-flight burst is discarded.
  - Reset in the middle of a move drops `move_start` and does not wait for `move_done`.
- Move codes:
  - 0..11 are valid turns (face*2 + dir).
  - 12..15 are terminators.
- Loader FSM (states L_IDLE, L_UNPACK):
  - In L_IDLE, `load`=1: register `seq` into a shift register, clear the index, set `loading`=1, go to L_UNPACK.
  - In L_UNPACK, process one move per cycle, starting at index 0.
    - Terminator: stop immediately; the terminator is not pushed.
    - Valid move and FIFO not full: push it.
    - Valid move and FIFO full: drop it, set `overflow`=1, keep scanning.
  - L_UNPACK ends after a terminator or after index MAX_LOAD-1. The next cycle is L_IDLE with `loading`=0.
  - `load` asserted while `loading`=1 is ignored.
  - First push lands in the FIFO 1 cycle after `load`.
- FIFO:
  - Circular buffer with wrapping read and write pointers.
  - Push and pop in the same cycle are allowed; `count` stays unchanged.
  - Pop on empty is impossible by construction.
  - `overflow` clears only on reset.
- Issue FSM (states I_IDLE, I_START, I_WAIT_BUSY, I_WAIT_DONE, I_SETTLE):
  - I_IDLE: if the FIFO is not empty and `move_done`=1, pop the head into `next_move` and go to I_START.
  - I_START: `move_start`=1 for exactly this cycle; go to I_WAIT_BUSY.
  - I_WAIT_BUSY: wait for `move_done`=0, then go to I_WAIT_DONE.
  - I_WAIT_DONE: wait for `move_done`=1, then load the settle counter with SETTLE_CYCLES-1 and go to I_SETTLE.
  - I_SETTLE: count down to 0, then go to I_IDLE.
  - `next_move` is held stable from I_START until the next pop.
- Start-to-start latency per move = 2 + executor busy time + SETTLE_CYCLES + 1 cycles.
- `seq_done`:
  - Pulses for one cycle when I_SETTLE exits to I_IDLE with FIFO empty and `loading`=0.
  - Does not pulse if no move has been issued since reset or since the previous pulse.
  - If a new burst arrives during I_SETTLE, the queue keeps issuing and `seq_done` waits until the next drain.

Decomposition:
- Package `rbot_moves_pkg`:
  - MOVE_W=4.
  - Face and direction move-code constants.
  - NUM_VALID_MOVES=12.
  - `is_terminator` function.
- Sub-module `move_fifo` (parameter DEPTH, 4-bit data):
  - Ports: push, pop, din, dout, full, empty, count.
  - Used only here, and separately verifiable.

Test Plan:
1. Load `seq` = {…,F,3,7,0} (moves 0,7,3 then terminator), executor model drops `move_done` 2 cycles after start and raises it 100 cycles later -> `next_move` sequence 0,7,3, three `move_start` pulses, one `seq_done` pulse after the third settle, `count` peaks at 3, `overflow`=0.
2. Load 50 valid moves, no terminator, with DEPTH=32 and the executor held busy -> `count`=32, `overflow`=1, remaining 18 dropped, first issued move = move 0.
3. Assert `load` again while `loading`=1 -> second burst ignored, `count` reflects only the first burst.
4. Simultaneous push and pop: second burst loads in the same cycle as a pop -> `count` unchanged that cycle, issue order preserved across pointer wrap-around (DEPTH=4, load 3+3 moves).
5. Assert `reset` during I_WAIT_DONE with 5 moves queued -> next cycle all outputs 0, `count`=0, no further `move_start`, and no `seq_done` even when `move_done` later rises.
6. Executor holds `move_done`=0 at queue fill -> no `move_start` until `move_done`=1, then the start follows within 2 cycles.
